// File: rtl/lsu.sv
// Load/store unit: one data-memory transaction per accepted start, with lane
// steering for stores, extraction/extension for loads, and fault reporting.
module lsu #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        is_store_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] store_data_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] load_data_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_be_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

    localparam logic [1:0] CauseNone      = 2'b00;
    localparam logic [1:0] CauseMisalign  = 2'b01;
    localparam logic [1:0] CauseTimeout   = 2'b10;
    localparam logic [1:0] CauseIllegal   = 2'b11;

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            fault_q, fault_d;
    logic [1:0]      cause_q, cause_d;
    logic [31:0]     ld_q, ld_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [3:0]      be_q, be_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;

    logic [1:0]      size;
    logic            illegal;
    logic            misaligned;
    logic [3:0]      be_new;
    logic [31:0]     wdata_new;
    logic [31:0]     shifted;
    logic [31:0]     load_val;

    // Decode the incoming request: legality, alignment and store lane steering.
    always_comb begin
        size       = funct3_i[1:0];
        // Size 11 is never legal; funct3[2] is only legal for LBU/LHU.
        illegal    = (size == 2'b11) || (funct3_i[2] && (is_store_i || size[1]));
        misaligned = ((size == 2'b01) && addr_i[0]) ||
                     ((size == 2'b10) && (addr_i[1:0] != 2'b00));
        be_new     = 4'b1111;
        wdata_new  = store_data_i;
        case (size)
            2'b00: begin
                be_new    = 4'b0001 << addr_i[1:0];
                wdata_new = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << addr_i[1:0];
                wdata_new = {2{store_data_i[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data_i;
            end
        endcase
    end

    // Extract the addressed lane from read data and extend it.
    always_comb begin
        shifted  = mem_rdata_i >> {off_q, 3'b000};
        case (funct3_q[1:0])
            2'b00:   load_val = {{24{~funct3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_val = {{16{~funct3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_val = shifted;
        endcase
    end

    // Next-state logic for the transaction FSM and its registered outputs.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        fault_d  = fault_q;
        cause_d  = cause_q;
        ld_d     = ld_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        funct3_d = funct3_q;
        off_d    = off_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    fault_d = 1'b0;
                    cause_d = CauseNone;
                    if (illegal) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                        cause_d = CauseIllegal;
                    end else if (misaligned) begin
                        state_d = StDone;
                        fault_d = 1'b1;
                        cause_d = CauseMisalign;
                    end else begin
                        state_d  = StReq;
                        cnt_d    = '0;
                        req_d    = 1'b1;
                        we_d     = is_store_i;
                        addr_d   = {addr_i[31:2], 2'b00};
                        wdata_d  = wdata_new;
                        be_d     = be_new;
                        funct3_d = funct3_i;
                        off_d    = addr_i[1:0];
                    end
                end
            end
            StReq: begin
                // Ready on the last permitted cycle still completes the access.
                if (mem_ready_i) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        ld_d = load_val;
                    end
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    req_d   = 1'b0;
                    fault_d = 1'b1;
                    cause_d = CauseTimeout;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            fault_q  <= 1'b0;
            cause_q  <= CauseNone;
            ld_q     <= '0;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            funct3_q <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            fault_q  <= fault_d;
            cause_q  <= cause_d;
            ld_q     <= ld_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            funct3_q <= funct3_d;
            off_q    <= off_d;
        end
    end

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StDone);
    assign load_data_o   = ld_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;
    assign mem_req_o     = req_q;
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign mem_be_o      = be_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit for the RV32I core. It sits directly downstream of the ALU: it takes the ALU's computed effective address plus the rs2 store data, then performs one data-memory transaction over a valid/ready request interface. For loads it returns a lane-aligned, sign- or zero-extended result; for stores it generates byte enables and replicated write data. It stalls the pipeline via `busy` for the whole transaction and reports misaligned, illegal and timed-out accesses.

## Interface
- `MAX_WAIT`, 16: maximum cycles `mem_req` is held without `mem_ready` before the access aborts (≥1).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: request a new access; accepted only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: loads LB 000, LH 001, LW 010, LBU 100, LHU 101; stores SB 000, SH 001, SW 010.
- `addr` in 32: effective address (ALU result).
- `store_data` in 32: rs2 value.
- `busy` out 1: high in every non-IDLE state.
- `done` out 1: one-cycle completion pulse (success or fault).
- `load_data` out 32: extended load result.
- `fault` out 1: valid with `done`; 1 = access failed.
- `fault_cause` out 2: 01 misaligned, 10 timeout, 11 illegal funct3, 00 none.
- `mem_req` out 1; `mem_we` out 1; `mem_addr` out 32, word-aligned (`addr[1:0]`=00); `mem_wdata` out 32; `mem_be` out 4.
- `mem_ready` in 1: completes the request in the same cycle; `mem_rdata` in 32 is valid in that cycle.

## Operation
- States: IDLE, REQ, DONE.
- IDLE + `start`:
  - Capture `is_store`, `funct3`, `addr`, `store_data`.
  - Legal and aligned → REQ; otherwise → DONE with a fault, and `mem_req` is never asserted.
- Illegal funct3: load 011/110/111; store with `funct3[2]`=1 or 011. Illegal takes priority over misaligned.
- Misaligned: halfword with `addr[0]`=1; word with `addr[1:0]`≠00.
- REQ: hold `mem_req`=1 with stable `mem_we`/`mem_addr`/`mem_wdata`/`mem_be` until `mem_ready`.
  - On `mem_ready`: latch load result (loads only) → DONE, no fault.
- Wait counter: cleared on REQ entry; increments each REQ cycle without `mem_ready`. If the count reaches `MAX_WAIT`-1 with no ready, go to DONE with fault 10 and drop `mem_req`. Ready in that same final cycle wins: the access succeeds.
- DONE: `done`=1 for one cycle → IDLE. `fault`/`fault_cause` hold until the next accepted `start`.
- Store lanes, with `off` = `addr[1:0]`:
  - SB: `mem_be` = 0001<<`off`, `mem_wdata` = {4{`store_data[7:0]`}}.
  - SH: `mem_be` = 0011<<`off`, `mem_wdata` = {2{`store_data[15:0]`}}.
  - SW: `mem_be` = 1111, `mem_wdata` = `store_data`.
- Loads: `mem_be` = lanes as for stores, `mem_we`=0. Result = `mem_rdata` >> (8·`off`), truncated to 8/16/32 bits, then sign-extended (LB/LH) or zero-extended (LBU/LHU).
- `load_data` updates only on a successful load; stores and faults leave it unchanged.
- `start` while busy is ignored.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `load_data`=0, `fault`=0, `fault_cause`=00, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_be`=0000, counter 0.
- All outputs are registered or decoded from registered state; there is no combinational path from `start` to memory outputs.
- Successful access: `start` at cycle 0; `mem_req` high from cycle 1; `mem_ready` at cycle 1+k; `done` at cycle 2+k. Minimum latency is 2 cycles.
- Fault at start (illegal or misaligned): `done` at cycle 1.
- Timeout: `mem_req` is high for exactly `MAX_WAIT` cycles; `done` follows in the next cycle.
- `start` in the DONE cycle is ignored; a new access can be accepted the cycle after `done`.
- `rst` mid-transaction: at that edge, return to reset values; `mem_req` is low in the following cycle and no `done` is issued.

## Test plan
- LW at `addr`=0x100, `mem_rdata`=0xDEADBEEF, ready on the first REQ cycle → `mem_addr`=0x100, `mem_be`=1111, `done` 2 cycles after start, `load_data`=0xDEADBEEF, `fault`=0.
- LB at `addr`=0x103, `mem_rdata`=0x80123456 → `mem_be`=1000, `load_data`=0xFFFFFF80. LBU at the same address → `load_data`=0x00000080.
- SH at `addr`=0x202, `store_data`=0x0000ABCD → `mem_we`=1, `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xABCDABCD. `load_data` unchanged.
- LW at 0x102 → `done` at cycle 1, `fault`=1, cause 01, `mem_req` never high. Store with `funct3`=100 → cause 11.
- `MAX_WAIT`=4 with `mem_ready` held low → `mem_req` high for 4 cycles, then `done` with cause 10. Repeat with ready in the 4th cycle → success, no fault.
- `rst` in the 2nd REQ cycle → all outputs return to reset values, no `done`. A subsequent LW completes normally.
